sd_spi_byte_engine: RTL
=======================

// Module: sd_spi_byte_engine
// PURPOSE
//  SPI-mode-0 byte shifter for the SD card path: sits directly upstream of the SD
//  interface, driving SD_CLK/SD_MOSI/SD_CS and sampling SD_MISO. The command/sector
//  FSM hands it one byte per transfer via a start/busy/done handshake. Full-duplex:
//  one byte out, one byte in. Two SCLK rates: slow for card init, fast for data.
// PARAMETERS
//  CLKDIV_SLOW  62  SCLK half-period = CLKDIV_SLOW+1 iCLK cycles (50 MHz -> ~397 kHz)
//  CLKDIV_FAST  1   SCLK half-period = CLKDIV_FAST+1 iCLK cycles (50 MHz -> 12.5 MHz)
//  INIT_CLOCKS  80  dummy SCLK cycles issued by an init sequence (SPI_INIT_CLOCKS_EN only)
// PORTS
//  iCLK        in   1  system clock; every flop on its rising edge
//  Reset       in   1  synchronous, active-low reset
//  iStart      in   1  request a byte transfer; sampled only in IDLE
//  iTxByte     in   8  byte to send, MSB first; latched when iStart is accepted
//  iFastMode   in   1  1 = CLKDIV_FAST, 0 = CLKDIV_SLOW; latched when iStart is accepted
//  iCSAssert   in   1  1 = drive SD_CS low (card selected)
//  iInit       in   1  request init clock sequence (ignored without SPI_INIT_CLOCKS_EN)
//  oRxByte     out  8  last received byte; valid from oDone onward
//  oBusy       out  1  transfer or init in progress
//  oDone       out  1  one-cycle pulse when a transfer or init completes
//  SD_CLK      out  1  SPI clock; idles low
//  SD_MOSI     out  1  SPI data out; idles high
//  SD_MISO     in   1  SPI data in
//  SD_CS       out  1  card select, active low
// BEHAVIOUR
//  - Reset (Reset==0 at a clock edge): SD_CLK=0, SD_MOSI=1, SD_CS=1, oBusy=0, oDone=0,
//    oRxByte=8'hFF, FSM in IDLE, all counters 0. A reset during a transfer aborts it
//    at that edge; no oDone pulse is produced.
//  - FSM states: IDLE, SHIFT_LO, SHIFT_HI, DONE (plus INIT with the macro).
//  - D = latched divisor. A half-period counter counts 0..D; the phase toggles when
//    the count reaches D.
//  - IDLE: if iStart is high at cycle N, latch iTxByte/iFastMode and go to SHIFT_LO.
//    From N+1: oBusy=1, SD_MOSI=bit7, SD_CLK=0.
//  - SHIFT_LO: SD_CLK=0 for D+1 cycles. Then go to SHIFT_HI and set SD_CLK=1. SD_MISO
//    is sampled into the rx shift register on the edge that raises SD_CLK.
//  - SHIFT_HI: SD_CLK=1 for D+1 cycles. Then SD_CLK=0. Bits 7..1: shift MOSI to the
//    next bit and return to SHIFT_LO. Bit 0: go to DONE.
//  - DONE, cycle N+1+16*(D+1): oDone=1 for one cycle. oRxByte is updated on the same
//    edge. oBusy=0, SD_MOSI=1. Return to IDLE. iStart may be accepted in this cycle.
//  - oBusy is high on cycles N+1 .. N+16*(D+1) inclusive.
//  - iStart while oBusy=1 is ignored and not queued. iTxByte and iFastMode changes
//    during a transfer have no effect.
//  - SD_CS <= ~iCSAssert is registered and updates only in IDLE/DONE. A change while
//    busy takes effect on the first edge after the transfer ends. SD_CS never toggles
//    while SD_CLK=1.
//  - Bit counter is 3 bits and wraps 7->0. DONE is decided from a separate last-bit
//    flag, not from the wrap.
// CONFIGURATION
//  SPI_INIT_CLOCKS_EN defined:
//  - In IDLE, iInit=1 -> INIT state. iInit has priority over a simultaneous iStart,
//    which is then dropped.
//  - INIT: INIT_CLOCKS SCLK cycles at CLKDIV_SLOW. SD_CS forced to 1 and SD_MOSI to 1
//    throughout. oBusy=1. Ends with a DONE pulse; oRxByte is unchanged.
//  - SD_CS then resumes ~iCSAssert.
//  SPI_INIT_CLOCKS_EN not defined: iInit is ignored, there is no INIT state, and the
//  port is still present.
// TESTING
//  1. Reset low 3 cycles, then release -> SD_CLK=0, SD_MOSI=1, SD_CS=1, oBusy=0,
//     oRxByte=8'hFF.
//  2. iFastMode=1, iTxByte=8'hA5, MISO model returns 8'h3C, pulse iStart at N ->
//     MOSI bits 1,0,1,0,0,1,0,1; 8 SCLK pulses of 4 cycles each; oDone at N+33;
//     oRxByte=8'h3C.
//  3. iFastMode=0, iTxByte=8'hFF -> SD_CLK high and low phases of exactly 63 cycles
//     each; oDone at N+1009; pulse iStart during busy -> no second transfer.
//  4. iCSAssert rises mid-transfer -> SD_CS stays 1 until after oDone, then goes 0.
//     Back-to-back: iStart held high -> second transfer begins the cycle after oDone.
//  5. Reset asserted after the 3rd SCLK rise -> next edge all outputs at reset values;
//     no oDone; a fresh iStart then completes normally.
//  6. With SPI_INIT_CLOCKS_EN, iInit and iStart together -> 80 slow SCLK cycles with
//     SD_CS=1 and MOSI=1, one oDone, iStart dropped. Without the macro -> iInit has
//     no effect and iStart runs.

Source files
------------

// File: rtl/sd_spi_byte_engine.sv
// sd_spi_byte_engine: SPI mode-0 full-duplex byte shifter for the SD card; SPI_INIT_CLOCKS_EN adds an 80-clock init sequence
module sd_spi_byte_engine #(
  parameter int CLKDIV_SLOW = 62,
  parameter int CLKDIV_FAST = 1,
  parameter int INIT_CLOCKS = 80
) (
  input  logic       iCLK,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iTxByte,
  input  logic       iFastMode,
  input  logic       iCSAssert,
  input  logic       iInit,
  output logic [7:0] oRxByte,
  output logic       oBusy,
  output logic       oDone,
  output logic       SD_CLK,
  output logic       SD_MOSI,
  input  logic       SD_MISO,
  output logic       SD_CS
);
  localparam int DMAX = CLKDIV_SLOW > CLKDIV_FAST ? CLKDIV_SLOW : CLKDIV_FAST;
  localparam int DW = $clog2(DMAX + 2);
  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, DONE
`ifdef SPI_INIT_CLOCKS_EN
    , INIT
`endif
  } stateT;
  stateT state, nextState;
  logic [DW-1:0] divisor, halfCnt;
  logic [7:0] txShift, rxShift;
  logic [2:0] bitCnt;
  logic lastBit, csReg, halfEnd, idleLike, startOk, initOk, inInit, initPhase, shifting;
`ifdef SPI_INIT_CLOCKS_EN
  localparam int IW = $clog2(INIT_CLOCKS + 1);
  logic [IW-1:0] initCnt;
  assign initOk = idleLike & iInit;
  assign inInit = state == INIT;
`else
  logic unusedInit;
  assign unusedInit = iInit & (INIT_CLOCKS != 0);
  assign initOk = 1'b0;
  assign inInit = 1'b0;
  assign initPhase = 1'b0;
`endif
  assign halfEnd = halfCnt == divisor;
  assign idleLike = state == IDLE || state == DONE;
  assign startOk = idleLike & iStart & ~initOk;
  assign shifting = state == SHIFT_LO || state == SHIFT_HI;
  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      state <= IDLE;
      divisor <= '0;
      halfCnt <= '0;
      txShift <= '0;
      rxShift <= '0;
      bitCnt <= '0;
      lastBit <= 1'b0;
      csReg <= 1'b1;
      oRxByte <= 8'hFF;
    end else begin
      state <= nextState;
      halfCnt <= (idleLike || halfEnd) ? '0 : halfCnt + 1'b1;
      csReg <= initOk ? 1'b1 : idleLike ? ~iCSAssert : csReg;
      if (startOk) begin
        divisor <= iFastMode ? DW'(CLKDIV_FAST) : DW'(CLKDIV_SLOW);
        txShift <= iTxByte;
        bitCnt <= '0;
        lastBit <= 1'b0;
      end
      if (initOk) divisor <= DW'(CLKDIV_SLOW);
      // MISO is captured on the edge that raises SD_CLK
      if (state == SHIFT_LO && halfEnd) rxShift <= {rxShift[6:0], SD_MISO};
      if (state == SHIFT_HI && halfEnd) begin
        txShift <= {txShift[6:0], 1'b0};
        bitCnt <= bitCnt + 3'd1;
        lastBit <= bitCnt == 3'd6;
        if (lastBit) oRxByte <= rxShift;
      end
    end
  end
`ifdef SPI_INIT_CLOCKS_EN
  always_ff @(posedge iCLK) begin
    if (!Reset) begin
      initCnt <= '0;
      initPhase <= 1'b0;
    end else if (initOk) begin
      initCnt <= '0;
      initPhase <= 1'b0;
    end else if (inInit && halfEnd) begin
      initPhase <= ~initPhase;
      if (initPhase) initCnt <= initCnt + 1'b1;
    end
  end
`endif
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: nextState = startOk ? SHIFT_LO : IDLE;
      SHIFT_LO: nextState = halfEnd ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: nextState = !halfEnd ? SHIFT_HI : lastBit ? DONE : SHIFT_LO;
`ifdef SPI_INIT_CLOCKS_EN
      INIT: nextState = (halfEnd && initPhase && initCnt == IW'(INIT_CLOCKS - 1)) ? DONE : INIT;
`endif
      default: nextState = IDLE;
    endcase
`ifdef SPI_INIT_CLOCKS_EN
    if (initOk) nextState = INIT;
`endif
  end
  always_comb begin
    oBusy = shifting || inInit;
    oDone = state == DONE;
    SD_CLK = state == SHIFT_HI || (inInit && initPhase);
    SD_MOSI = shifting ? txShift[7] : 1'b1;
    SD_CS = csReg;
  end
endmodule
